jpeg_bit_packer: RTL and testbench
==================================

Name: jpeg_bit_packer

Overview:
- Sits directly downstream of the coefficient encoder and the Huffman code lookup in the entropy-coding path.
- Accepts variable-length bit fields of 0-16 bits and packs them MSB-first into a byte stream.
- Inserts JPEG 0x00 stuffing after every 0xFF byte.
- On request, pads the final partial byte with 1s and marks the last byte, for consumption by the output FIFO / marker writer.

Parameters:
- ACC_WIDTH, 32, bit-accumulator width; must be >= 24. The in_ready threshold is ACC_WIDTH-16.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  packer can accept a beat this cycle.
- in_bits  input  16  field value, right-justified; bits at and above in_length are ignored (masked).
- in_length  input  5  number of valid bits, 0-16; values 17-31 are treated as 16.
- in_flush  input  1  sideband on a beat: after appending this beat's bits, pad to a byte boundary and end the stream.
- out_valid  output  1  out_data holds a byte.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  packed byte.
- out_last  output  1  qualifies the final byte of a flushed stream.

Behaviour:
- Core state: accumulator acc[ACC_WIDTH-1:0], left-justified, and count held (0..ACC_WIDTH).
- Input handshake:
  - Beat transfers when in_valid && in_ready.
  - in_ready = (state==RUN) && (held <= ACC_WIDTH-16).
  - in_ready is combinational from registers only; it never depends on in_valid.
- Append rule: on a transfer, acc gets the field's MSB first, directly below the already-held bits; held += len.
- A zero-length beat changes nothing except that its in_flush is still honoured.
- Output is registered. A byte emitted to out_data is popped from acc (held -= 8) when it is loaded into the output register, not at handshake.
- out_valid/out_data/out_last hold stable while out_valid && !out_ready.
- Minimum latency: a byte completed by a beat accepted in cycle N appears with out_valid in cycle N+1.
- Same-cycle input accept and byte pop are both allowed: held_next = held + len - 8.
- FSM states:
  - RUN: load the output register whenever it is empty or being consumed and held >= 8.
    - If the loaded byte is 0xFF and stuffing is enabled, go to STUFF.
    - If a flush beat was accepted, go to PAD once all whole bytes are out.
  - STUFF: next loaded byte is 0x00 (acc untouched), then return to the origin state (RUN or PAD).
  - PAD: if held==0, mark the previously loaded byte out_last and go to DONE; if no byte was emitted this stream, emit nothing and go straight to DONE. Otherwise fill the remaining (8-held) bits with 1s, load that byte, set held=0, and set out_last unless stuffing follows.
  - DONE: wait for the last byte to be consumed, then go to RUN.
- in_ready is 0 in STUFF, PAD and DONE.
- out_last goes on the stuff byte when the final data byte is 0xFF.
- Reset mid-stream discards acc, held and any pending output byte. All outputs are then 0: out_valid=0, out_data=0x00, out_last=0, in_ready=1 from the first cycle after reset deasserts. State is RUN.
- Full condition: held > ACC_WIDTH-16 drops in_ready; out_ready stalls propagate back within one cycle.
- Empty condition: out_valid=0 when held < 8 and no stuff or pad byte is pending.

Optional Feature:
- Macro: JPEG_BIT_PACKER_STUFF_EN.
- Defined: 0x00 is inserted after every emitted 0xFF (data or pad byte); STUFF state is present.
- Undefined: STUFF state and its logic are removed, bytes are emitted raw, and out_last always lands on the final data/pad byte.

Test Plan:
- Packing: beat {in_bits=0x5, len 3} then {in_bits=0x1F, len 5} -> single byte 0xBF; out_last=0.
- Stuffing (macro defined): beat {0xFF, len 8} -> bytes 0xFF, 0x00. With macro undefined -> 0xFF only.
- Flush padding: beat {0x2, len 3, in_flush=1} -> byte 0x5F with out_last=1, then in_ready returns to 1. A beat {0x1, len 1, flush} -> 0xFF, 0x00 with out_last on the 0x00 (macro defined).
- Backpressure: hold out_ready=0 while sending {0xABCD, len 16} twice -> in_ready drops after held exceeds 16. out_data stays 0xAB until released, then the bytes are 0xAB, 0xCD, 0xAB, 0xCD in order with no loss or duplication.
- Zero length and saturation: beats {0x1234, len 0} and {0xFFFF, len 20} -> the first adds nothing; the second behaves as len 16 (0xFF, 0x00, 0xFF, 0x00 with stuffing).
- Reset mid-operation: assert reset for one cycle with 12 bits held and out_valid=1 -> next cycle out_valid=0, out_data=0x00, in_ready=1. A subsequent {0xA5, len 8} yields exactly 0xA5.

Source files
------------

// File: rtl/jpeg_bit_packer.sv
// ---------------------------------------------------------------------------
// jpeg_bit_packer
//
// Packs variable-length bit fields (0-16 bits) MSB-first into a byte stream
// for the JPEG entropy-coding path. Inserts a 0x00 byte after every 0xFF.
// On a flush beat, pads the final partial byte with 1s and marks the last
// byte of the stream.
//
// Optional feature macro: JPEG_BIT_PACKER_STUFF_EN
//   defined   -> 0x00 stuffing after every emitted 0xFF (STUFF state present)
//   undefined -> bytes are emitted raw, no STUFF state
//
// Parameters:
//   ACC_WIDTH  bit-accumulator width (>= 24)
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   packer can accept a beat this cycle
//   in_bits    field value, right-justified (bits above in_length ignored)
//   in_length  number of valid bits, 0-16 (17-31 treated as 16)
//   in_flush   pad to a byte boundary and end the stream after this beat
//   out_valid  out_data holds a byte
//   out_ready  downstream accepts the byte
//   out_data   packed byte
//   out_last   final byte of a flushed stream
// ---------------------------------------------------------------------------
module jpeg_bit_packer #(
    parameter int ACC_WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_bits,
    input  logic [4:0]  in_length,
    input  logic        in_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    localparam int HW = $clog2(ACC_WIDTH + 1);
    localparam logic [HW-1:0] BYTE_BITS = HW'(8);
    localparam logic [HW-1:0] THRESH    = HW'(ACC_WIDTH - 16);

    localparam logic [1:0] RUN   = 2'd0;
`ifdef JPEG_BIT_PACKER_STUFF_EN
    localparam logic [1:0] STUFF = 2'd1;
`endif
    localparam logic [1:0] PAD   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [HW-1:0]        held;
    logic                 flush_pending;
`ifdef JPEG_BIT_PACKER_STUFF_EN
    logic [1:0]           stuff_return;
    logic                 stuff_last;
`endif

    logic [4:0]           eff_len;
    logic [15:0]          field;
    logic [ACC_WIDTH-1:0] field_just;
    logic                 accept;
    logic [ACC_WIDTH-1:0] merged;
    logic [HW-1:0]        total;
    logic                 out_free;
    logic                 pop_ok;
    logic [7:0]           top_byte;
    logic [HW-1:0]        held_after;
    logic [ACC_WIDTH-1:0] acc_after;
    logic                 flush_now;
    logic [7:0]           pad_byte;

    // Once a flush beat has been taken, no further beats are accepted until
    // the stream has been closed, so the next stream cannot mix into this one.
    assign in_ready = (state == RUN) && !flush_pending && (held <= THRESH);

    // The incoming field is merged into the accumulator before the output
    // load decision, so a byte completed by this beat can be loaded in the
    // same cycle and popped together with the append.
    always_comb begin
        eff_len    = (in_length > 5'd16) ? 5'd16 : in_length;
        field      = in_bits & (16'hFFFF >> (5'd16 - eff_len));
        field_just = {field, {(ACC_WIDTH-16){1'b0}}} << (5'd16 - eff_len);
        accept     = in_valid && in_ready;
        merged     = accept ? (acc | (field_just >> held)) : acc;
        total      = accept ? (held + HW'(eff_len)) : held;
        out_free   = !out_valid || out_ready;
        top_byte   = merged[ACC_WIDTH-1 -: 8];
        pop_ok     = (state == RUN) && out_free && (total >= BYTE_BITS);
        held_after = pop_ok ? (total - BYTE_BITS) : total;
        acc_after  = pop_ok ? (merged << 8) : merged;
        flush_now  = flush_pending || (accept && in_flush);
        pad_byte   = acc[ACC_WIDTH-1 -: 8] | (8'hFF >> held);
    end

    // Main sequencer: accumulator, output register and stream state.
    // The PAD held==0 case may raise out_last on a byte already presented,
    // because the stream end is only learnt after that byte was loaded.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            acc           <= '0;
            held          <= '0;
            flush_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= 8'h00;
            out_last      <= 1'b0;
`ifdef JPEG_BIT_PACKER_STUFF_EN
            stuff_return  <= RUN;
            stuff_last    <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                RUN: begin
                    acc  <= acc_after;
                    held <= held_after;
                    if (accept && in_flush)
                        flush_pending <= 1'b1;
                    if (pop_ok) begin
                        out_valid <= 1'b1;
                        out_data  <= top_byte;
                        out_last  <= 1'b0;
                    end
                    if (flush_now && (held_after < BYTE_BITS)) begin
                        if (pop_ok && (held_after == '0)) begin
`ifdef JPEG_BIT_PACKER_STUFF_EN
                            if (top_byte == 8'hFF) begin
                                state        <= STUFF;
                                stuff_return <= DONE;
                                stuff_last   <= 1'b1;
                            end else
`endif
                            begin
                                out_last <= 1'b1;
                                state    <= DONE;
                            end
                        end else begin
`ifdef JPEG_BIT_PACKER_STUFF_EN
                            if (pop_ok && (top_byte == 8'hFF)) begin
                                state        <= STUFF;
                                stuff_return <= PAD;
                                stuff_last   <= 1'b0;
                            end else
`endif
                            state <= PAD;
                        end
                    end
`ifdef JPEG_BIT_PACKER_STUFF_EN
                    else if (pop_ok && (top_byte == 8'hFF)) begin
                        state        <= STUFF;
                        stuff_return <= RUN;
                        stuff_last   <= 1'b0;
                    end
`endif
                end
`ifdef JPEG_BIT_PACKER_STUFF_EN
                STUFF: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= 8'h00;
                        out_last  <= stuff_last;
                        state     <= stuff_return;
                    end
                end
`endif
                PAD: begin
                    if (held == '0) begin
                        if (out_valid && !out_ready)
                            out_last <= 1'b1;
                        state <= DONE;
                    end else if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= pad_byte;
                        acc       <= '0;
                        held      <= '0;
`ifdef JPEG_BIT_PACKER_STUFF_EN
                        if (pad_byte == 8'hFF) begin
                            out_last     <= 1'b0;
                            state        <= STUFF;
                            stuff_return <= DONE;
                            stuff_last   <= 1'b1;
                        end else
`endif
                        begin
                            out_last <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_free) begin
                        state         <= RUN;
                        flush_pending <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// ---------------------------------------------------------------------------
// tb_jpeg_bit_packer
//
// Self-checking bench for jpeg_bit_packer: a table of directed beats with
// their expected bytes, hand-written backpressure and reset sequences, and
// randomized streams checked against a bit-queue model of the packing rules.
// ---------------------------------------------------------------------------
module tb_jpeg_bit_packer;

`ifdef JPEG_BIT_PACKER_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bits;
    logic [4:0]  in_length;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct {
        logic [15:0] bits;
        logic [4:0]  len;
        logic        flush;
        int          nexp;
        logic [31:0] exp_bytes;
        int          last_idx;
    } vector_t;

    int      compared   = 0;
    int      mismatched = 0;
    int      ready_mode = 0;
    bit      hold_off   = 1'b0;
    byte_t   got_q[$];
    byte_t   exp_q[$];
    bit      mbits[$];
    vector_t vec[10];

    bit         stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    always #5 clock = ~clock;

    jpeg_bit_packer #(.ACC_WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_length (in_length),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Output side: drive out_ready for the coming edge, record every byte
    // that will be consumed, and check that a stalled byte stays put.
    always @(negedge clock) begin
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (reset || hold_off) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                compared++;
                if (!(out_valid === 1'b1 && out_data === stall_data && out_last === stall_last)) begin
                    mismatched++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=0x%02h last=%b, wanted valid=1 data=0x%02h last=%b",
                             out_valid, out_data, out_last, stall_data, stall_last);
                end
            end
            if (out_valid && out_ready)
                got_q.push_back('{out_data, out_last});
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    // Present one beat and hold it until the packer takes it.
    task automatic applyStimulus(input logic [15:0] b, input logic [4:0] l, input logic f, output bit ok);
        int n;
        @(negedge clock);
        in_bits   = b;
        in_length = l;
        in_flush  = f;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            in_flush = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        ok = 1'b1;
    endtask

    // Wait for the expected number of bytes, allow a few more cycles to
    // catch extras, then compare the recorded bytes one by one.
    task automatic checkStream(input string name);
        int n;
        int m;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clock);
            n++;
        end
        repeat (6) @(negedge clock);
        checkOutput({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            checkOutput($sformatf("%s_byte%0d_data", name, i), 32'(got_q[i].data), 32'(exp_q[i].data));
            checkOutput($sformatf("%s_byte%0d_last", name, i), 32'(got_q[i].last), 32'(exp_q[i].last));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Reference model: the stream as a plain queue of bits, cut into bytes.
    task automatic model_accept(input logic [15:0] b, input logic [4:0] l, input logic f);
        int    eff;
        byte_t tmp;
        logic [7:0] v;
        eff = (l > 5'd16) ? 16 : int'(l);
        for (int i = eff - 1; i >= 0; i--)
            mbits.push_back(b[i]);
        if (f)
            while (mbits.size() % 8 != 0)
                mbits.push_back(1'b1);
        while (mbits.size() >= 8) begin
            v = 8'h00;
            for (int k = 0; k < 8; k++)
                v = {v[6:0], mbits.pop_front()};
            exp_q.push_back('{v, 1'b0});
            if (STUFF_ON && v == 8'hFF)
                exp_q.push_back('{8'h00, 1'b0});
        end
        if (f && exp_q.size() > 0) begin
            tmp = exp_q.pop_back();
            tmp.last = 1'b1;
            exp_q.push_back(tmp);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;
        int nb;
        logic [4:0] len;
        logic       fl;
        logic [15:0] bits;

        vec[0] = '{16'h0005, 5'd3,  1'b0, 0, 32'h00000000, -1};
        vec[1] = '{16'h001F, 5'd5,  1'b0, 1, 32'hBF000000, -1};
        vec[3] = '{16'h0002, 5'd3,  1'b1, 1, 32'h5F000000,  0};
        vec[5] = '{16'h1234, 5'd0,  1'b0, 0, 32'h00000000, -1};
        vec[7] = '{16'h00A5, 5'd8,  1'b1, 1, 32'hA5000000,  0};
        vec[8] = '{16'h0000, 5'd0,  1'b1, 0, 32'h00000000, -1};
        vec[9] = '{16'h0003, 5'd6,  1'b0, 0, 32'h00000000, -1};
        if (STUFF_ON) begin
            vec[2] = '{16'h00FF, 5'd8,  1'b0, 2, 32'hFF000000, -1};
            vec[4] = '{16'h0001, 5'd1,  1'b1, 2, 32'hFF000000,  1};
            vec[6] = '{16'hFFFF, 5'd20, 1'b0, 4, 32'hFF00FF00, -1};
        end else begin
            vec[2] = '{16'h00FF, 5'd8,  1'b0, 1, 32'hFF000000, -1};
            vec[4] = '{16'h0001, 5'd1,  1'b1, 1, 32'hFF000000,  0};
            vec[6] = '{16'hFFFF, 5'd20, 1'b0, 2, 32'hFFFF0000, -1};
        end

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bits   = 16'h0000;
        in_length = 5'd0;
        in_flush  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data",  32'(out_data),  32'h00);
        checkOutput("reset_out_last",  32'(out_last),  32'd0);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vec[i].bits, vec[i].len, vec[i].flush, ok);
            for (int j = 0; j < vec[i].nexp; j++)
                exp_q.push_back('{vec[i].exp_bytes[31 - 8*j -: 8], (j == vec[i].last_idx)});
            checkStream($sformatf("vec%0d", i));
            if (vec[i].flush)
                checkOutput($sformatf("vec%0d_ready_after_flush", i), 32'(in_ready), 32'd1);
        end
        // Close out the 6 bits left by the last vector: 000011 + 11 -> 0x0F.
        applyStimulus(16'h0003, 5'd2, 1'b1, ok);
        exp_q.push_back('{8'h0F, 1'b1});
        checkStream("tail_flush");

        $display("[TB] backpressure sequence");
        ready_mode = 1;
        applyStimulus(16'hABCD, 5'd16, 1'b0, ok);
        applyStimulus(16'hABCD, 5'd16, 1'b0, ok);
        @(negedge clock);
        checkOutput("bp_in_ready_low", 32'(in_ready),  32'd0);
        checkOutput("bp_out_valid",    32'(out_valid), 32'd1);
        checkOutput("bp_data_first",   32'(out_data),  32'hAB);
        repeat (5) @(negedge clock);
        checkOutput("bp_data_held",    32'(out_data),  32'hAB);
        ready_mode = 0;
        exp_q.push_back('{8'hAB, 1'b0});
        exp_q.push_back('{8'hCD, 1'b0});
        exp_q.push_back('{8'hAB, 1'b0});
        exp_q.push_back('{8'hCD, 1'b0});
        checkStream("bp");

        $display("[TB] reset mid-stream sequence");
        ready_mode = 1;
        applyStimulus(16'h0ABC, 5'd12, 1'b0, ok);
        applyStimulus(16'h005A, 5'd8,  1'b0, ok);
        @(negedge clock);
        checkOutput("rst_pre_out_valid", 32'(out_valid), 32'd1);
        hold_off = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(out_data),  32'h00);
        checkOutput("rst_out_last",  32'(out_last),  32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clock);
        hold_off = 1'b0;
        got_q.delete();
        exp_q.delete();
        mbits.delete();
        ready_mode = 0;
        applyStimulus(16'h00A5, 5'd8, 1'b0, ok);
        exp_q.push_back('{8'hA5, 1'b0});
        checkStream("rst_after");

        $display("[TB] randomized streams against reference model");
        ready_mode = 2;
        for (int s = 0; s < 25; s++) begin
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                bits = 16'($urandom);
                len  = 5'($urandom_range(0, 20));
                fl   = (b == nb - 1);
                if (fl && len == 5'd0)
                    len = 5'd1;
                repeat ($urandom_range(0, 2)) @(negedge clock);
                applyStimulus(bits, len, fl, ok);
                if (ok)
                    model_accept(bits, len, fl);
            end
            checkStream($sformatf("rand%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
